// File: rtl/ones_frame_accum_if.sv
// Handshake/data bundle for ones_frame_accum.
//   Upstream side  : valid_i, ones_i, zeros_i -> ready_o
//   Downstream side: valid_o, ones_total_o, zeros_total_o, diff_o, major_o, err_o -> ready_i
// slave modport is the accumulator's view; master is the driving/observing side.
interface ones_frame_accum_if #(
  parameter int unsigned WIDTH_I   = 8,
  parameter int unsigned FRAME_LEN = 4
);
  localparam int unsigned WIDTH_O = $clog2(WIDTH_I + 1);
  localparam int unsigned WIDTH_T = $clog2(WIDTH_I * FRAME_LEN + 1);

  logic                      valid_i;
  logic [WIDTH_O-1:0]        ones_i;
  logic [WIDTH_O-1:0]        zeros_i;
  logic                      ready_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [WIDTH_T-1:0]        ones_total_o;
  logic [WIDTH_T-1:0]        zeros_total_o;
  logic signed [WIDTH_T:0]   diff_o;
  logic                      major_o;
  logic                      err_o;

  modport slave (
    input  valid_i, ones_i, zeros_i, ready_i,
    output ready_o, valid_o, ones_total_o, zeros_total_o, diff_o, major_o, err_o
  );

  modport master (
    output valid_i, ones_i, zeros_i, ready_i,
    input  ready_o, valid_o, ones_total_o, zeros_total_o, diff_o, major_o, err_o
  );
endinterface

// File: rtl/ones_frame_accum.sv
// Frame-level bit-statistics accumulator.
// Sums FRAME_LEN per-word (ones, zeros) count pairs into frame totals and
// presents totals, signed balance (ones - zeros) and a strict-majority flag
// over a valid/ready handshake. err_o is sticky until reset and flags any
// accepted pair whose counts do not add up to WIDTH_I.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - ones_frame_accum_if.slave (count-pair input + frame result output)
module ones_frame_accum #(
  parameter int unsigned WIDTH_I   = 8,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ones_frame_accum_if.slave      bus
);
  localparam int unsigned WIDTH_O = $clog2(WIDTH_I + 1);
  localparam int unsigned WIDTH_T = $clog2(WIDTH_I * FRAME_LEN + 1);
  localparam int unsigned WIDTH_C = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [WIDTH_O:0]   C_PAIR = (WIDTH_O + 1)'(WIDTH_I);
  localparam logic [WIDTH_C-1:0] C_LAST = WIDTH_C'(FRAME_LEN - 1);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_valid;
  logic                r_err;
  logic [WIDTH_C-1:0]  r_word_cnt;
  logic [WIDTH_T-1:0]  r_ones_acc;
  logic [WIDTH_T-1:0]  r_zeros_acc;
  logic [WIDTH_T-1:0]  r_ones_tot;
  logic [WIDTH_T-1:0]  r_zeros_tot;

  logic                w_accept;
  logic                w_last;
  logic                w_bad;
  logic [WIDTH_O:0]    w_pair_sum;
  logic [WIDTH_T-1:0]  w_ones_sum;
  logic [WIDTH_T-1:0]  w_zeros_sum;

  always_comb begin
    w_accept    = bus.valid_i & r_ready & (r_state == ST_ACCUM);
    w_last      = (r_word_cnt == C_LAST);
    // One extra bit so an inconsistent pair cannot wrap back to WIDTH_I.
    w_pair_sum  = {1'b0, bus.ones_i} + {1'b0, bus.zeros_i};
    w_bad       = (w_pair_sum != C_PAIR);
    w_ones_sum  = r_ones_acc  + WIDTH_T'(bus.ones_i);
    w_zeros_sum = r_zeros_acc + WIDTH_T'(bus.zeros_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_ACCUM;
      r_ready     <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
      r_ones_acc  <= '0;
      r_zeros_acc <= '0;
      r_ones_tot  <= '0;
      r_zeros_tot <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_bad) r_err <= 1'b1;
            if (w_last) begin
              // Final word goes straight into the output registers; the
              // partial accumulators are cleared on the result handshake.
              r_ones_tot  <= w_ones_sum;
              r_zeros_tot <= w_zeros_sum;
              r_word_cnt  <= '0;
              r_state     <= ST_HOLD;
              r_ready     <= 1'b0;
              r_valid     <= 1'b1;
            end else begin
              r_ones_acc  <= w_ones_sum;
              r_zeros_acc <= w_zeros_sum;
              r_word_cnt  <= r_word_cnt + WIDTH_C'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.ready_i) begin
            r_ones_acc  <= '0;
            r_zeros_acc <= '0;
            r_state     <= ST_ACCUM;
            r_valid     <= 1'b0;
            r_ready     <= 1'b1;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.ready_o       = r_ready;
  assign bus.valid_o       = r_valid;
  assign bus.ones_total_o  = r_ones_tot;
  assign bus.zeros_total_o = r_zeros_tot;
  assign bus.diff_o        = $signed({1'b0, r_ones_tot}) - $signed({1'b0, r_zeros_tot});
  assign bus.major_o       = (r_ones_tot > r_zeros_tot);
  assign bus.err_o         = r_err;
endmodule

// File: tb/tb_ones_frame_accum.sv
module tb_ones_frame_accum;
  logic clk_i;
  logic rst_i;

  ones_frame_accum_if #(.WIDTH_I(8), .FRAME_LEN(4)) ifa ();
  ones_frame_accum_if #(.WIDTH_I(1), .FRAME_LEN(1)) ifb ();

  ones_frame_accum #(.WIDTH_I(8), .FRAME_LEN(4)) dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifa)
  );

  ones_frame_accum #(.WIDTH_I(1), .FRAME_LEN(1)) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Which DUT is under test (0: 8-bit words x4, 1: 1-bit words x1) and its geometry.
  int sel;
  int m_wi, m_fl, m_wt;

  // Reference model: frame contents kept as queues, totals formed by summing them.
  int  q_ones[$];
  int  q_zeros[$];
  bit  m_hold, m_rdy, m_err;
  int  m_otot, m_ztot;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  task automatic model_reset();
    q_ones.delete();
    q_zeros.delete();
    m_hold = 1'b0;
    m_rdy  = 1'b0;
    m_err  = 1'b0;
    m_otot = 0;
    m_ztot = 0;
  endtask

  task automatic compare_outputs();
    int o_rdy, o_vld, o_ot, o_zt, o_diff, o_maj, o_err;
    if (sel == 0) begin
      o_rdy = int'(ifa.ready_o);       o_vld = int'(ifa.valid_o);
      o_ot  = int'(ifa.ones_total_o);  o_zt  = int'(ifa.zeros_total_o);
      o_diff = int'($signed(ifa.diff_o));
      o_maj = int'(ifa.major_o);       o_err = int'(ifa.err_o);
    end else begin
      o_rdy = int'(ifb.ready_o);       o_vld = int'(ifb.valid_o);
      o_ot  = int'(ifb.ones_total_o);  o_zt  = int'(ifb.zeros_total_o);
      o_diff = int'($signed(ifb.diff_o));
      o_maj = int'(ifb.major_o);       o_err = int'(ifb.err_o);
    end
    check_val("ready_o", o_rdy, m_rdy);
    check_val("valid_o", o_vld, m_hold);
    check_val("ones_total", o_ot, m_otot);
    check_val("zeros_total", o_zt, m_ztot);
    check_val("diff", o_diff, m_otot - m_ztot);
    check_val("major", o_maj, (m_otot > m_ztot) ? 1 : 0);
    check_val("err", o_err, m_err);
  endtask

  task automatic drive(input bit v, input int on, input int zn, input bit rdy);
    if (sel == 0) begin
      ifa.valid_i = v; ifa.ones_i = 4'(on); ifa.zeros_i = 4'(zn); ifa.ready_i = rdy;
      ifb.valid_i = 1'b0; ifb.ready_i = 1'b1;
    end else begin
      ifb.valid_i = v; ifb.ones_i = 1'(on); ifb.zeros_i = 1'(zn); ifb.ready_i = rdy;
      ifa.valid_i = 1'b0; ifa.ready_i = 1'b1;
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model to the next edge.
  task automatic step(input bit v, input int on, input int zn, input bit rdy);
    int so, sz;
    drive(v, on, zn, rdy);
    @(negedge clk_i);
    compare_outputs();
    if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0;
        m_rdy  = 1'b1;
      end
    end else begin
      if (m_rdy && v) begin
        q_ones.push_back(on);
        q_zeros.push_back(zn);
        if (on + zn != m_wi) m_err = 1'b1;
        if (q_ones.size() == m_fl) begin
          so = 0; sz = 0;
          foreach (q_ones[i])  so += q_ones[i];
          foreach (q_zeros[i]) sz += q_zeros[i];
          m_otot = so % (1 << m_wt);
          m_ztot = sz % (1 << m_wt);
          q_ones.delete();
          q_zeros.delete();
          m_hold = 1'b1;
        end
      end
      m_rdy = !m_hold;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 1'b1);
    rst_i = 1'b1;
    model_reset();
    #2;
    compare_outputs();
    @(posedge clk_i);
    #1;
    compare_outputs();
    rst_i = 1'b0;
  endtask

  task automatic select(input int s);
    sel = s;
    if (s == 0) begin m_wi = 8; m_fl = 4; m_wt = 6; end
    else        begin m_wi = 1; m_fl = 1; m_wt = 1; end
  endtask

  initial begin
    int on, zn;
    rst_i = 1'b1;
    ifa.valid_i = 1'b0; ifa.ones_i = '0; ifa.zeros_i = '0; ifa.ready_i = 1'b1;
    ifb.valid_i = 1'b0; ifb.ones_i = '0; ifb.zeros_i = '0; ifb.ready_i = 1'b1;
    select(0);
    @(posedge clk_i);
    #1;
    do_reset();
    step(0, 0, 0, 1);

    // Balanced frame, back-to-back, then a beat right after the handshake.
    step(1, 8, 0, 1); step(1, 0, 8, 1); step(1, 3, 5, 1); step(1, 5, 3, 1);
    step(1, 8, 0, 1); step(1, 8, 0, 1);

    // All-ones frame with two-cycle gaps between beats.
    do_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    end
    step(0, 0, 0, 1);

    // Downstream stall for 5 cycles with an upstream beat held pending.
    for (int i = 0; i < 4; i++) step(1, 1, 7, 0);
    for (int i = 0; i < 5; i++) step(1, 2, 6, 0);
    step(1, 2, 6, 1);
    step(1, 2, 6, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // Inconsistent pair inside a frame, then a clean frame: err must persist.
    do_reset();
    step(0, 0, 0, 1);
    step(1, 5, 5, 1); step(1, 4, 4, 1); step(1, 4, 4, 1); step(1, 4, 4, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 6, 2, 1);
    step(0, 0, 0, 1);

    // Reset mid-frame, then a full frame that must not include the lost beats.
    do_reset();
    step(0, 0, 0, 1);
    step(1, 8, 0, 1); step(1, 8, 0, 1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2, 6, 1);
    step(0, 0, 0, 1);
    // Reset while a result is held.
    for (int i = 0; i < 4; i++) step(1, 7, 1, 0);
    step(0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1);

    // Randomized traffic, occasionally inconsistent, with rare resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) begin
          on = $urandom_range(0, 15); zn = $urandom_range(0, 15);
        end else begin
          on = $urandom_range(0, 8);  zn = 8 - on;
        end
        step(1'($urandom_range(0, 3) != 0), on, zn, 1'($urandom_range(0, 2) != 0));
      end
    end

    // Single-bit words, one word per frame.
    select(1);
    do_reset();
    step(0, 0, 0, 1);
    step(1, 1, 0, 1); step(1, 0, 1, 1); step(1, 0, 1, 1); step(0, 0, 0, 1);
    for (int i = 0; i < 150; i++) begin
      on = $urandom_range(0, 1);
      zn = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : 1 - on;
      step(1'($urandom_range(0, 3) != 0), on, zn, 1'($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ones_frame_accum.md
# ones_frame_accum

Frame-level bit-statistics accumulator placed directly downstream of the combinational zeros/ones counter. It consumes one per-word ones/zeros count pair per accepted beat and sums FRAME_LEN words into frame totals. It then presents the totals, a signed ones-minus-zeros balance and a majority flag to the next stage over a valid/ready handshake. It also sticky-flags any input pair that is inconsistent with the word width.

## Interface
- WIDTH_I, 8: width of the data word counted upstream; ≥1.
- FRAME_LEN, 4: words per frame; ≥1.
- WIDTH_O (localparam): $clog2(WIDTH_I+1), width of per-word count inputs (matches upstream counter outputs).
- WIDTH_T (localparam): $clog2(WIDTH_I*FRAME_LEN+1), width of frame totals.
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  upstream count pair valid.
- ones_i  in  WIDTH_O  ones count of current word.
- zeros_i  in  WIDTH_O  zeros count of current word.
- ready_o  out  1  block can accept a count pair this cycle.
- valid_o  out  1  frame result valid.
- ready_i  in  1  downstream accepts frame result.
- ones_total_o  out  WIDTH_T  sum of ones_i over frame.
- zeros_total_o  out  WIDTH_T  sum of zeros_i over frame.
- diff_o  out  WIDTH_T+1, signed  ones_total_o − zeros_total_o.
- major_o  out  1  1 when ones_total_o > zeros_total_o strictly.
- err_o  out  1  sticky: some accepted pair had ones_i+zeros_i ≠ WIDTH_I.

## Operation
- FSM, two states: ACCUM, HOLD. Reset state ACCUM.
- ACCUM: ready_o=1, valid_o=0. Beat accepted when valid_i & ready_o.
  - On accept: ones_acc += ones_i, zeros_acc += zeros_i (zero-extended to WIDTH_T), word_cnt += 1.
  - Accept with word_cnt==FRAME_LEN−1: final sums go to output registers, word_cnt→0, next state HOLD.
  - valid_i=0: no state change. Gaps of any length are allowed mid-frame.
- HOLD: ready_o=0, valid_o=1, outputs stable.
  - valid_o & ready_i: clear accumulators, next state ACCUM.
  - No bypass: a beat offered in the same cycle is not accepted. It is accepted no earlier than the next cycle.
- diff_o is computed from the registered totals and is sign-correct over −WIDTH_I*FRAME_LEN..+WIDTH_I*FRAME_LEN. major_o=0 on a tie.
- err_o:
  - Set on any accepted beat with ones_i+zeros_i ≠ WIDTH_I, sum evaluated at WIDTH_O+1 bits with no wrap.
  - Cleared only by rst_i.
  - The offending counts are still accumulated.
- Totals cannot overflow WIDTH_T, since each input is ≤ WIDTH_I when consistent. Inconsistent inputs may wrap modulo 2^WIDTH_T. err_o flags that case.
- FRAME_LEN=1: every accepted beat moves directly to HOLD.

## Timing
- Reset (async assert, synchronous-safe release):
  - state=ACCUM, word_cnt=0, accumulators=0.
  - ready_o=1 from the first active edge after release.
  - valid_o=0, ones_total_o=0, zeros_total_o=0, diff_o=0, major_o=0, err_o=0.
- Latency: valid_o rises on the clock edge that accepts the last word of the frame, so result is visible in the following cycle.
- Throughput: one word per cycle in ACCUM. At least one dead cycle per frame: with ready_i held 1, the frame period is FRAME_LEN+1 cycles.
- Output registers change only on the HOLD entry edge or at reset. They stay stable while valid_o=1 & ready_i=0.
- ready_o depends on state only, not combinationally on ready_i or valid_i.
- Reset mid-frame or during HOLD discards the partial frame and any pending result, with no output pulse.

## Test plan
- WIDTH_I=8, FRAME_LEN=4; beats (ones,zeros) = (8,0),(0,8),(3,5),(5,3), ready_i=1 → valid_o for 1 cycle with ones_total_o=16, zeros_total_o=16, diff_o=0, major_o=0, err_o=0. Next beat accepted one cycle after the handshake.
- Beats (8,0)×4 with valid_i gaps of 2 cycles between beats → ones_total_o=32, zeros_total_o=0, diff_o=+32, major_o=1. ready_o stays 1 during the gaps.
- Frame (1,7)×4 with ready_i=0 for 5 cycles after valid_o → totals 4/28, diff_o=−24. Outputs stable and ready_o=0 throughout. Upstream beat held with valid_i=1 is not accepted until the cycle after ready_i=1.
- Beat (5,5) inside a frame of (5,5),(4,4),(4,4),(4,4) → err_o=1 from the next cycle and stays 1 across later valid frames. Totals are 17/17.
- Reset asserted after 2 of 4 beats, then a full frame (2,6)×4 → result 8/24, with no contribution from the pre-reset beats. All outputs are at their reset values during reset.
- FRAME_LEN=1, WIDTH_I=1; beats (1,0),(0,1) with ready_i=1 → two results, diff_o=+1 then −1. Each result is followed by a ready_o=0 cycle.
